// File: rtl/subpix_pkg.sv
// Shared constants and types for the sub-pixel divider scheduler.
// Requester indices, operand/result widths and the in-flight tag format.
package subpix_pkg;

    localparam int NREQ   = 3;
    localparam int REQ_A  = 0;
    localparam int REQ_B  = 1;
    localparam int REQ_C  = 2;

    localparam int OP_W   = 15;
    localparam int RES_W  = 32;
    localparam int ID_W   = 2;
    localparam int STAT_W = 16;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // Pointer moves to the requester just after the one that won.
    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] id);
        return (id == ID_W'(NREQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

endpackage

// File: rtl/subpix_rr_arb.sv
// Combinational round-robin selector over the three requesters.
// Search begins at ptr and wraps; the first asserted request wins.
module subpix_rr_arb
    import subpix_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt
);

    logic [2:0]      idx;
    logic [ID_W-1:0] sel;
    logic            found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'(NREQ)) begin
                idx = idx - 3'(NREQ);
            end
            sel = idx[ID_W-1:0];
            if (!found && req[sel]) begin
                gnt[sel] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/subpix_div_sched.sv
// Schedules three requesters onto one pipelined divider and tags results by id.
// Optional statistics counters are built when SUBPIX_DIV_SCHED_STATS_EN is defined.
module subpix_div_sched
    import subpix_pkg::*;
#(
    parameter int DIV_LAT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic signed [OP_W-1:0]  num0,
    input  logic signed [OP_W-1:0]  num1,
    input  logic signed [OP_W-1:0]  num2,
    input  logic signed [OP_W-1:0]  den0,
    input  logic signed [OP_W-1:0]  den1,
    input  logic signed [OP_W-1:0]  den2,
    output logic [NREQ-1:0]         gnt,
    output logic signed [OP_W-1:0]  div_dataa,
    output logic signed [OP_W-1:0]  div_datab,
    input  logic [RES_W-1:0]        div_result,
    input  logic                    div_dbz,
    output logic                    out_valid,
    output logic [ID_W-1:0]         out_id,
    output logic [RES_W-1:0]        out_result,
    output logic                    out_dbz
`ifdef SUBPIX_DIV_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]       stat_busy,
    output logic [STAT_W-1:0]       stat_dbz
`endif
);

    logic [ID_W-1:0]        ptr;
    logic [NREQ-1:0]        arb_gnt;
    logic                   any_gnt;
    logic [ID_W-1:0]        gnt_id;
    logic signed [OP_W-1:0] num_sel;
    logic signed [OP_W-1:0] den_sel;
    tag_t                   tag_q [DIV_LAT+1];

    subpix_rr_arb u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // Grant is forced low while reset is held so nothing is accepted.
    assign gnt     = rst ? arb_gnt : '0;
    assign any_gnt = |gnt;

    always_comb begin
        gnt_id  = ID_W'(REQ_A);
        num_sel = num0;
        den_sel = den0;
        if (gnt[REQ_B]) begin
            gnt_id  = ID_W'(REQ_B);
            num_sel = num1;
            den_sel = den1;
        end else if (gnt[REQ_C]) begin
            gnt_id  = ID_W'(REQ_C);
            num_sel = num2;
            den_sel = den2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            div_dataa <= '0;
            div_datab <= '0;
        end else if (any_gnt) begin
            ptr       <= ptr_after(gnt_id);
            div_dataa <= num_sel;
            div_datab <= den_sel;
        end
    end

    // Tag pipe mirrors divider latency plus the output register stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s <= DIV_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: any_gnt, id: gnt_id};
            for (int s = 1; s <= DIV_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_result <= '0;
            out_dbz    <= 1'b0;
        end else begin
            out_valid <= tag_q[DIV_LAT].valid;
            if (tag_q[DIV_LAT].valid) begin
                out_id     <= tag_q[DIV_LAT].id;
                out_result <= div_result;
                out_dbz    <= div_dbz;
            end
        end
    end

`ifdef SUBPIX_DIV_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_busy <= '0;
            stat_dbz  <= '0;
        end else begin
            if (any_gnt && (stat_busy != '1)) begin
                stat_busy <= stat_busy + STAT_W'(1);
            end
            if (out_valid && out_dbz && (stat_dbz != '1)) begin
                stat_dbz <= stat_dbz + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_subpix_div_sched.sv
// Directed bench for subpix_div_sched with a behavioural pipelined divider stub.
// Build with SUBPIX_DIV_SCHED_STATS_EN to also exercise the statistics counters.
module tb_subpix_div_sched;

    localparam int DIV_LAT = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [2:0]          req = '0;
    logic signed [14:0]  num0 = '0, num1 = '0, num2 = '0;
    logic signed [14:0]  den0 = '0, den1 = '0, den2 = '0;
    logic [2:0]          gnt;
    logic signed [14:0]  div_dataa, div_datab;
    logic [31:0]         div_result;
    logic                div_dbz;
    logic                out_valid;
    logic [1:0]          out_id;
    logic [31:0]         out_result;
    logic                out_dbz;
`ifdef SUBPIX_DIV_SCHED_STATS_EN
    logic [15:0]         stat_busy, stat_dbz;
`endif

    subpix_div_sched #(.DIV_LAT(DIV_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .num0       (num0),
        .num1       (num1),
        .num2       (num2),
        .den0       (den0),
        .den1       (den1),
        .den2       (den2),
        .gnt        (gnt),
        .div_dataa  (div_dataa),
        .div_datab  (div_datab),
        .div_result (div_result),
        .div_dbz    (div_dbz),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .out_result (out_result),
        .out_dbz    (out_dbz)
`ifdef SUBPIX_DIV_SCHED_STATS_EN
        ,
        .stat_busy  (stat_busy),
        .stat_dbz   (stat_dbz)
`endif
    );

    always #5 clk = ~clk;

    // Divider stub: result appears DIV_LAT edges after operands change.
    logic [31:0] pipe_r [DIV_LAT];
    logic        pipe_z [DIV_LAT];
    int          ia, ib;
    always @(posedge clk) begin
        ia = $signed(div_dataa);
        ib = $signed(div_datab);
        for (int k = DIV_LAT - 1; k > 0; k--) begin
            pipe_r[k] <= pipe_r[k-1];
            pipe_z[k] <= pipe_z[k-1];
        end
        pipe_r[0] <= (ib == 0) ? 32'd0 : 32'(ia / ib);
        pipe_z[0] <= (ib == 0);
    end
    assign div_result = pipe_r[DIV_LAT-1];
    assign div_dbz    = pipe_z[DIV_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [1:0]  id;
        logic [31:0] res;
        logic        dbz;
    } ev_t;
    ev_t evq[$];

    always @(negedge clk) begin
        if (out_valid) evq.push_back('{cyc, out_id, out_result, out_dbz});
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected event table for the six-op round-robin burst.
    logic [1:0]  rr_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [31:0] rr_res [6] = '{32'd10, 32'hFFFF_FFF8, 32'hFFFF_C001,
                                32'd10, 32'hFFFF_FFF8, 32'hFFFF_C001};
    logic [2:0]  rr_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    int g0;

    initial begin
        // Reset state, and grant suppressed while reset is low
        req = 3'b111;
        @(negedge clk); #1;
        check("rst_gnt",   32'(gnt), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_dataa", 32'(div_dataa), 32'd0);
        check("rst_res",   out_result, 32'd0);
        req = 3'b000;
        tick(2);
        rst = 1'b1;

        // Single request b: 100/20, 9 edges latency
        tick(2);
        req = 3'b010; num1 = 15'sd100; den1 = 15'sd20;
        #1;
        check("t1_gnt", 32'(gnt), 32'b010);
        g0 = cyc + 1;
        @(negedge clk);
        req = 3'b000;
        check("t1_dataa", 32'(div_dataa), 32'd100);
        check("t1_datab", 32'(div_datab), 32'd20);
        tick(12);
        check("t1_n", 32'(evq.size()), 32'd1);
        if (evq.size() >= 1) begin
            check("t1_lat", 32'(evq[0].cyc - g0), 32'd9);
            check("t1_id",  32'(evq[0].id), 32'd1);
            check("t1_res", evq[0].res, 32'd5);
            check("t1_dbz", 32'(evq[0].dbz), 32'd0);
        end
        check("t1_hold_v",  32'(out_valid), 32'd0);
        check("t1_hold_id", 32'(out_id), 32'd1);
        check("t1_hold_r",  out_result, 32'd5);
        check("t1_hold_a",  32'(div_dataa), 32'd100);
        evq.delete();

        // Single request c with negative quotient (ptr moves 2 -> 0)
        req = 3'b100; num2 = -15'sd21; den2 = 15'sd4;
        #1;
        check("t2_gnt", 32'(gnt), 32'b100);
        @(negedge clk);
        req = 3'b000;
        tick(12);
        check("t2_n", 32'(evq.size()), 32'd1);
        if (evq.size() >= 1) begin
            check("t2_id",  32'(evq[0].id), 32'd2);
            check("t2_res", evq[0].res, 32'hFFFF_FFFB);
        end
        evq.delete();

        // All three held: a,b,c,a,b,c and back-to-back results in order
        num0 = 15'sd50;    den0 = 15'sd5;
        num1 = -15'sd60;   den1 = 15'sd7;
        num2 = 15'sd16383; den2 = -15'sd1;
        req = 3'b111;
        g0 = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(rr_gnt[i]));
            @(negedge clk);
        end
        req = 3'b000;
        tick(14);
        check("rr_n", 32'(evq.size()), 32'd6);
        if (evq.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("rr_cyc%0d", i), 32'(evq[i].cyc - g0), 32'(9 + i));
                check($sformatf("rr_id%0d", i),  32'(evq[i].id), 32'(rr_id[i]));
                check($sformatf("rr_res%0d", i), evq[i].res, rr_res[i]);
            end
        end
        evq.delete();

        // Divide by zero on requester a (ptr 0 -> 1)
        req = 3'b001; num0 = 15'sd7; den0 = 15'sd0;
        @(negedge clk);
        req = 3'b000;
        check("dbz_datab", 32'(div_datab), 32'd0);
        tick(12);
        check("dbz_n", 32'(evq.size()), 32'd1);
        if (evq.size() >= 1) begin
            check("dbz_flag", 32'(evq[0].dbz), 32'd1);
            check("dbz_id",   32'(evq[0].id), 32'd0);
        end
`ifdef SUBPIX_DIV_SCHED_STATS_EN
        check("stat_dbz", 32'(stat_dbz), 32'd1);
        check("stat_busy9", 32'(stat_busy), 32'd9);
`endif
        evq.delete();

        // req=101 with ptr=1: c first, then a
        req = 3'b101; num0 = 15'sd9; den0 = 15'sd3; num2 = 15'sd8; den2 = 15'sd2;
        #1;
        check("p1_gnt", 32'(gnt), 32'b100);
        @(negedge clk); #1;
        check("p0_gnt", 32'(gnt), 32'b001);
        @(negedge clk);
        req = 3'b000;
        tick(12);
        check("p_n", 32'(evq.size()), 32'd2);
        if (evq.size() >= 2) begin
            check("p_id0", 32'(evq[0].id), 32'd2);
            check("p_r0",  evq[0].res, 32'd4);
            check("p_id1", 32'(evq[1].id), 32'd0);
            check("p_r1",  evq[1].res, 32'd3);
        end
        evq.delete();

        // Reset with two ops in flight: both must vanish
        req = 3'b011; num1 = 15'sd40; den1 = 15'sd8;
        #1;
        check("r_gnt0", 32'(gnt), 32'b010);
        @(negedge clk); #1;
        check("r_gnt1", 32'(gnt), 32'b001);
        @(negedge clk);
        rst = 1'b0;
        req = 3'b111;
        #1;
        check("r_gnt_low", 32'(gnt), 32'd0);
        check("r_dataa",   32'(div_dataa), 32'd0);
        check("r_id",      32'(out_id), 32'd0);
        tick(3);
        req = 3'b000;
        rst = 1'b1;
        #1;
        check("r_res",  out_result, 32'd0);
        check("r_datab", 32'(div_datab), 32'd0);
`ifdef SUBPIX_DIV_SCHED_STATS_EN
        check("r_stat_busy", 32'(stat_busy), 32'd0);
        check("r_stat_dbz",  32'(stat_dbz), 32'd0);
`endif
        tick(15);
        check("r_noval", 32'(evq.size()), 32'd0);
        req = 3'b111;
        #1;
        check("r_ptr0", 32'(gnt), 32'b001);
        @(negedge clk);
        req = 3'b000;
        tick(12);
        check("r_post_n", 32'(evq.size()), 32'd1);
        evq.delete();

`ifdef SUBPIX_DIV_SCHED_STATS_EN
        // Saturation of the busy counter
        req = 3'b111;
        tick(70000);
        req = 3'b000;
        tick(2);
        check("sat_busy", 32'(stat_busy), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
